// File: rtl/warp_issue_scheduler_if.sv
// Bundle of the per-warp instruction-buffer stream, the issue slot and the writeback
// port of warp_issue_scheduler. The slave modport is the scheduler's view.
interface warp_issue_scheduler_if #(
    parameter int ARCH_LEN  = 32,
    parameter int NUM_WARPS = 8,
    parameter int OP_BITS   = 7,
    parameter int REG_BITS  = 8
);
    localparam int WID = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0]          ibuf_valid;
    logic [NUM_WARPS-1:0]          ibuf_ready;
    logic [ARCH_LEN*NUM_WARPS-1:0] ibuf_pc;
    logic [OP_BITS*NUM_WARPS-1:0]  ibuf_op;
    logic [REG_BITS*NUM_WARPS-1:0] ibuf_rd;

    logic                          issue_valid;
    logic                          issue_ready;
    logic [WID-1:0]                issue_warp;
    logic [ARCH_LEN-1:0]           issue_pc;
    logic [OP_BITS-1:0]            issue_op;
    logic [REG_BITS-1:0]           issue_rd;

    logic                          wb_valid;
    logic [WID-1:0]                wb_warp;
    logic [REG_BITS-1:0]           wb_rd;
    logic                          wb_err;
    logic                          idle;

    modport master (
        output ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, issue_ready, wb_valid, wb_warp, wb_rd,
        input  ibuf_ready, issue_valid, issue_warp, issue_pc, issue_op, issue_rd, wb_err, idle
    );

    modport slave (
        input  ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, issue_ready, wb_valid, wb_warp, wb_rd,
        output ibuf_ready, issue_valid, issue_warp, issue_pc, issue_op, issue_rd, wb_err, idle
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Round-robin per-warp issue stage with a per-warp WAW scoreboard and a registered
// issue slot that holds its contents until the execute stage accepts it.
module warp_issue_scheduler #(
    parameter int ARCH_LEN    = 32,
    parameter int NUM_WARPS   = 8,
    parameter int OP_BITS     = 7,
    parameter int REG_BITS    = 8,
    parameter int MAX_PENDING = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    warp_issue_scheduler_if.slave bus
);
    localparam int WID = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0][MAX_PENDING-1:0]               sb_valid_q, sb_valid_d;
    logic [NUM_WARPS-1:0][MAX_PENDING-1:0][REG_BITS-1:0] sb_rd_q, sb_rd_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [WID-1:0]       issue_warp_q, issue_warp_d;
    logic [ARCH_LEN-1:0]  issue_pc_q, issue_pc_d;
    logic [OP_BITS-1:0]   issue_op_q, issue_op_d;
    logic [REG_BITS-1:0]  issue_rd_q, issue_rd_d;
    logic [WID-1:0]       last_grant_q, last_grant_d;
    logic                 wb_err_q, wb_err_d;

    logic [NUM_WARPS-1:0] rd_hit, sb_full, eligible;
    logic                 load, grant_found;
    logic [WID-1:0]       grant_warp, cand;
    logic [REG_BITS-1:0]  grant_rd;
    logic                 alloc_done, clear_done;

    // Eligibility looks only at registered scoreboard state, so a writeback in the
    // same cycle never unblocks a warp.
    always_comb begin
        rd_hit   = '0;
        sb_full  = '0;
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int e = 0; e < MAX_PENDING; e++) begin
                if (sb_valid_q[w][e] && sb_rd_q[w][e] == bus.ibuf_rd[REG_BITS*w +: REG_BITS])
                    rd_hit[w] = 1'b1;
            end
            sb_full[w]  = &sb_valid_q[w];
            eligible[w] = bus.ibuf_valid[w] &&
                          (bus.ibuf_rd[REG_BITS*w +: REG_BITS] == '0 || (!rd_hit[w] && !sb_full[w]));
        end
    end

    assign load = !issue_valid_q || bus.issue_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_warp  = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = last_grant_q + WID'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_warp  = cand;
            end
        end
        // No handshake is offered while reset is held.
        grant_found = grant_found && load && rst_n;
    end

    always_comb begin
        bus.ibuf_ready = '0;
        if (grant_found)
            bus.ibuf_ready[grant_warp] = 1'b1;
    end

    assign grant_rd = bus.ibuf_rd[REG_BITS*grant_warp +: REG_BITS];

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_warp_d  = issue_warp_q;
        issue_pc_d    = issue_pc_q;
        issue_op_d    = issue_op_q;
        issue_rd_d    = issue_rd_q;
        last_grant_d  = last_grant_q;
        sb_valid_d    = sb_valid_q;
        sb_rd_d       = sb_rd_q;
        wb_err_d      = wb_err_q;
        alloc_done    = 1'b0;
        clear_done    = 1'b0;

        if (grant_found) begin
            issue_valid_d = 1'b1;
            issue_warp_d  = grant_warp;
            issue_pc_d    = bus.ibuf_pc[ARCH_LEN*grant_warp +: ARCH_LEN];
            issue_op_d    = bus.ibuf_op[OP_BITS*grant_warp +: OP_BITS];
            issue_rd_d    = grant_rd;
            last_grant_d  = grant_warp;
            if (grant_rd != '0) begin
                for (int e = 0; e < MAX_PENDING; e++) begin
                    if (!alloc_done && !sb_valid_q[grant_warp][e]) begin
                        sb_valid_d[grant_warp][e] = 1'b1;
                        sb_rd_d[grant_warp][e]    = grant_rd;
                        alloc_done                = 1'b1;
                    end
                end
            end
        end else if (bus.issue_ready) begin
            issue_valid_d = 1'b0;
        end

        // The clear can never hit the entry just allocated: a matching entry blocks allocation.
        if (bus.wb_valid) begin
            if (bus.wb_rd != '0) begin
                for (int e = 0; e < MAX_PENDING; e++) begin
                    if (!clear_done && sb_valid_q[bus.wb_warp][e] &&
                        sb_rd_q[bus.wb_warp][e] == bus.wb_rd) begin
                        sb_valid_d[bus.wb_warp][e] = 1'b0;
                        clear_done                 = 1'b1;
                    end
                end
            end
            if (!clear_done)
                wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            issue_pc_q    <= '0;
            issue_op_q    <= '0;
            issue_rd_q    <= '0;
            last_grant_q  <= WID'(NUM_WARPS - 1);
            sb_valid_q    <= '0;
            sb_rd_q       <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            issue_pc_q    <= issue_pc_d;
            issue_op_q    <= issue_op_d;
            issue_rd_q    <= issue_rd_d;
            last_grant_q  <= last_grant_d;
            sb_valid_q    <= sb_valid_d;
            sb_rd_q       <= sb_rd_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_warp  = issue_warp_q;
    assign bus.issue_pc    = issue_pc_q;
    assign bus.issue_op    = issue_op_q;
    assign bus.issue_rd    = issue_rd_q;
    assign bus.wb_err      = wb_err_q;
    assign bus.idle        = !issue_valid_q && !(|sb_valid_q);
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler: round-robin order, WAW stalls, full
// scoreboard, back-pressure, writeback errors and asynchronous reset.
module tb_warp_issue_scheduler;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;
    int   exp_w;

    warp_issue_scheduler_if bus ();

    warp_issue_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int w, input logic v, input logic [31:0] pc,
                         input logic [6:0] op, input logic [7:0] rd);
        bus.ibuf_valid[w]       = v;
        bus.ibuf_pc[32*w +: 32] = pc;
        bus.ibuf_op[7*w +: 7]   = op;
        bus.ibuf_rd[8*w +: 8]   = rd;
    endtask

    task automatic do_reset();
        bus.ibuf_valid  = '0;
        bus.wb_valid    = 1'b0;
        bus.issue_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic do_wb(input logic [2:0] w, input logic [7:0] rd);
        bus.wb_valid = 1'b1;
        bus.wb_warp  = w;
        bus.wb_rd    = rd;
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst_n    = 1'b0;
        bus.ibuf_valid  = '0;
        bus.ibuf_pc     = '0;
        bus.ibuf_op     = '0;
        bus.ibuf_rd     = '0;
        bus.issue_ready = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_warp     = '0;
        bus.wb_rd       = '0;
        for (int w = 0; w < 8; w++)
            set_w(w, 1'b1, 32'h100 + 32'(4*w), 7'(w + 1), 8'(10 + w));
        #2;
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_issue_fields", {bus.issue_warp, bus.issue_pc, bus.issue_op, bus.issue_rd}, 0);
        check("rst_ibuf_ready", bus.ibuf_ready, 0);
        check("rst_idle", bus.idle, 1);
        check("rst_wb_err", bus.wb_err, 0);

        // Round robin over all warps; each warp moves to a new rd once accepted.
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            exp_w = k % 8;
            check("rr_ready", bus.ibuf_ready, 64'(1) << exp_w);
            tick();
            check("rr_valid", bus.issue_valid, 1);
            check("rr_warp", bus.issue_warp, 64'(exp_w));
            check("rr_pc", bus.issue_pc, (k < 8) ? 64'(32'h100 + 32'(4*exp_w)) : 64'h200);
            check("rr_op", bus.issue_op, 64'(exp_w + 1));
            check("rr_rd", bus.issue_rd, (k < 8) ? 64'(10 + exp_w) : 64'd20);
            set_w(exp_w, 1'b1, 32'h200 + 32'(4*exp_w), 7'(exp_w + 1), 8'(20 + exp_w));
            #1;
        end
        check("rr_next_w1", bus.ibuf_ready, 64'h02);

        // WAW stall on warp 2, released by a writeback.
        do_reset();
        set_w(2, 1'b1, 32'h20, 7'h11, 8'd5);
        #1;
        check("waw_ready0", bus.ibuf_ready, 64'h04);
        tick();
        check("waw_issue_rd", bus.issue_rd, 5);
        set_w(2, 1'b1, 32'h24, 7'h12, 8'd5);
        #1;
        check("waw_blocked", bus.ibuf_ready, 0);
        tick();
        check("waw_slot_drained", bus.issue_valid, 0);
        check("waw_still_blocked", bus.ibuf_ready, 0);
        tick();
        do_wb(3'd2, 8'd5);
        #1;
        check("waw_same_cycle_wb", bus.ibuf_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("waw_unblocked", bus.ibuf_ready, 64'h04);
        check("waw_no_issue_yet", bus.issue_valid, 0);
        tick();
        check("waw_regrant_valid", bus.issue_valid, 1);
        check("waw_regrant_pc", bus.issue_pc, 64'h24);
        check("waw_wb_err", bus.wb_err, 0);

        // Full scoreboard on warp 1.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            set_w(1, 1'b1, 32'h10 + 32'(r), 7'h01, 8'(r));
            #1;
            check("full_fill_ready", bus.ibuf_ready, 64'h02);
            tick();
            check("full_fill_rd", bus.issue_rd, 64'(r));
        end
        set_w(1, 1'b1, 32'h16, 7'h02, 8'd6);
        #1;
        check("full_blocked", bus.ibuf_ready, 0);
        tick();
        check("full_slot_empty", bus.issue_valid, 0);
        set_w(1, 1'b1, 32'h99, 7'h03, 8'd0);
        #1;
        check("full_rd0_ready", bus.ibuf_ready, 64'h02);
        tick();
        check("full_rd0_issued", {bus.issue_valid, bus.issue_pc}, {1'b1, 32'h99});
        set_w(1, 1'b1, 32'h16, 7'h02, 8'd6);
        do_wb(3'd1, 8'd3);
        #1;
        check("full_wb_same_cycle", bus.ibuf_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("full_freed_ready", bus.ibuf_ready, 64'h02);
        tick();
        check("full_rd6_issued", {bus.issue_valid, bus.issue_rd}, {1'b1, 8'd6});
        check("full_not_idle", bus.idle, 0);

        // Back-pressure: slot held while issue_ready is low.
        do_reset();
        bus.issue_ready = 1'b0;
        set_w(0, 1'b1, 32'hA0, 7'h0A, 8'd0);
        set_w(3, 1'b1, 32'hA3, 7'h0B, 8'd0);
        #1;
        check("bp_first_ready", bus.ibuf_ready, 64'h01);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_ready_low", bus.ibuf_ready, 0);
            check("bp_slot_stable", {bus.issue_valid, bus.issue_warp, bus.issue_pc}, {1'b1, 3'd0, 32'hA0});
            tick();
        end
        bus.issue_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.ibuf_ready, 64'h08);
        tick();
        check("bp_next_grant", {bus.issue_warp, bus.issue_pc}, {3'd3, 32'hA3});

        // Writeback that matches nothing.
        bus.ibuf_valid = '0;
        do_wb(3'd3, 8'd7);
        tick();
        bus.wb_valid = 1'b0;
        check("wberr_set", bus.wb_err, 1);
        check("wberr_idle", bus.idle, 1);
        tick();
        tick();
        check("wberr_sticky", bus.wb_err, 1);

        // Asynchronous reset mid-stream with three pending entries on warp 5.
        for (int r = 1; r <= 3; r++) begin
            set_w(5, 1'b1, 32'h50 + 32'(r), 7'h05, 8'(r));
            tick();
        end
        check("ar_pre_valid", bus.issue_valid, 1);
        check("ar_pre_busy", bus.idle, 0);
        for (int w = 0; w < 8; w++)
            set_w(w, 1'b1, 32'h300 + 32'(w), 7'h07, 8'd0);
        #1;
        check("ar_pre_next", bus.ibuf_ready, 64'h40);
        rst_n = 1'b0;
        #1;
        check("ar_valid_dropped", bus.issue_valid, 0);
        check("ar_idle", bus.idle, 1);
        check("ar_wb_err_cleared", bus.wb_err, 0);
        check("ar_ready_low", bus.ibuf_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ar_w0_priority", bus.ibuf_ready, 64'h01);
        tick();
        check("ar_w0_issued", {bus.issue_valid, bus.issue_warp, bus.issue_pc}, {1'b1, 3'd0, 32'h300});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
